sram_arbiter: RTL and testbench

- Two-requester controller that shares one single-port synchronous SRAM (8-bit address, bidirectional 8-bit data, single rw strobe: 0 = read, 1 = write).
- Round-robin arbitration between requesters.
- Sequences each access: drives address, rw and tristate data, captures read data, returns a one-cycle ack.
- Sits between two bus masters (e.g. CPU and DMA) and the sram instance.

---
 rtl/sram_arbiter.sv | 107 ++++++++++
 tb/tb_sram_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port front end for a single-port synchronous SRAM (optional grant counters: SRAM_ARB_STATS_EN)
module sram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
`ifdef SRAM_ARB_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       p0_grant_cnt,
   output logic [15:0]       p1_grant_cnt,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              mem_rw,
   output logic              busy,
   output logic              grant_id
);
   typedef enum logic [2:0] {IDLE, WR, RD, RCAP, DONE} state_t;
   state_t state, state_nx;
   logic rr, gid, sel, grant;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   assign sel = (p0_req & p1_req) ? rr : p1_req;
   assign grant = (state == IDLE) && (p0_req | p1_req);
   assign mem_addr = lat_addr;
   assign mem_data = mem_rw ? lat_wdata : 'z;
   assign grant_id = gid;
   // next state and per-state outputs; only WR ever raises the write strobe
   always_comb begin
      state_nx = state;
      mem_rw = 1'b0;
      p0_ack = 1'b0;
      p1_ack = 1'b0;
      busy = state != IDLE;
      case (state)
         IDLE: if (grant) state_nx = (sel ? p1_we : p0_we) ? WR : RD;
         WR: begin
            mem_rw = 1'b1;
            state_nx = DONE;
         end
         RD: state_nx = RCAP;
         RCAP: state_nx = DONE;
         DONE: begin
            p0_ack = !gid;
            p1_ack = gid;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // state register, grant latch and round-robin pointer (moves only on contention)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         rr <= 1'b0;
         gid <= 1'b0;
         lat_addr <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            gid <= sel;
            lat_addr <= sel ? p1_addr : p0_addr;
            lat_wdata <= sel ? p1_wdata : p0_wdata;
            if (p0_req & p1_req) rr <= ~sel;
         end
      end
   end
   // read capture: the SRAM presents the word during RCAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rdata <= '0;
         p1_rdata <= '0;
      end else if (state == RCAP) begin
         if (gid) p1_rdata <= mem_data;
         else p0_rdata <= mem_data;
      end
   end
`ifdef SRAM_ARB_STATS_EN
   // per-port grant counters; clear wins over a same-cycle grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_grant_cnt <= '0;
         p1_grant_cnt <= '0;
      end else if (stats_clr) begin
         p0_grant_cnt <= '0;
         p1_grant_cnt <= '0;
      end else if (grant) begin
         if (sel) p1_grant_cnt <= p1_grant_cnt + 16'd1;
         else p0_grant_cnt <= p0_grant_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench with a transaction-level model checked every cycle
module tb_sram_arbiter;
   logic clk = 1'b0, rst_n = 1'b1;
   logic p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [7:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
   logic p0_ack, p1_ack, mem_rw, busy, grant_id;
   logic [7:0] p0_rdata, p1_rdata, mem_addr;
   wire [7:0] mem_data;
`ifdef SRAM_ARB_STATS_EN
   logic stats_clr = 1'b0;
   logic [15:0] p0_grant_cnt, p1_grant_cnt;
`endif
   int total = 0, bad = 0;
   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
`ifdef SRAM_ARB_STATS_EN
      .stats_clr(stats_clr), .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt),
`endif
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_rw(mem_rw), .busy(busy), .grant_id(grant_id)
   );

   // synchronous SRAM: writes while rw=1, otherwise registers a read and drives the bus
   logic [7:0] sram [256];
   logic [7:0] sram_q = '0;
   initial for (int i = 0; i < 256; i++) sram[i] <= 8'(i);
   always @(posedge clk) begin
      if (mem_rw) sram[mem_addr] <= mem_data;
      else sram_q <= sram[mem_addr];
   end
   assign mem_data = mem_rw ? 'z : sram_q;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h @%0t", n, a, e, $time);
      end
   endtask

   // model: phase counts cycles since the grant; an access lasts 2 (write) or 3 (read) cycles
   int ph = 0, len;
   bit m_we, m_own, m_rr;
   logic [7:0] m_addr, m_wd;
   logic [7:0] mm [256];
   logic [7:0] m_rd [2];
   initial for (int i = 0; i < 256; i++) mm[i] = 8'(i);
   always @(negedge clk) begin
      if (!rst_n) begin
         ph = 0; m_rr = 0; m_rd[0] = 0; m_rd[1] = 0;
         chk("rst_busy", 32'(busy), 0);
         chk("rst_rw", 32'(mem_rw), 0);
         chk("rst_ack", 32'({p0_ack, p1_ack}), 0);
         chk("rst_rdata", 32'({p0_rdata, p1_rdata}), 0);
         chk("rst_gid", 32'(grant_id), 0);
         chk("rst_addr", 32'(mem_addr), 0);
      end else begin
         len = m_we ? 2 : 3;
         if (ph == len && !m_we) m_rd[m_own] = mm[m_addr];
         chk("busy", 32'(busy), 32'(ph != 0));
         chk("mem_rw", 32'(mem_rw), 32'(ph == 1 && m_we));
         chk("p0_ack", 32'(p0_ack), 32'(ph == len && !m_own));
         chk("p1_ack", 32'(p1_ack), 32'(ph == len && m_own));
         chk("p0_rdata", 32'(p0_rdata), 32'(m_rd[0]));
         chk("p1_rdata", 32'(p1_rdata), 32'(m_rd[1]));
         if (ph != 0) begin
            chk("grant_id", 32'(grant_id), 32'(m_own));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
         end
         if (mem_rw) chk("bus_wr", 32'(mem_data), 32'(m_wd));
         else chk("bus_rd", 32'(mem_data), 32'(sram_q));
         if (ph == 2 && !m_we) chk("bus_word", 32'(mem_data), 32'(mm[m_addr]));
         if (ph == len) begin
            if (m_we) mm[m_addr] = m_wd;
            ph = 0;
         end else if (ph != 0) ph++;
         else if (p0_req | p1_req) begin
            m_own = (p0_req & p1_req) ? m_rr : p1_req;
            if (p0_req & p1_req) m_rr = !m_own;
            m_we = m_own ? p1_we : p0_we;
            m_addr = m_own ? p1_addr : p0_addr;
            m_wd = m_own ? p1_wdata : p0_wdata;
            ph = 1;
         end
      end
   end

   // grant order and write-strobe width recorders
   bit rec = 0;
   bit gq [$];
   int rw_cnt = 0;
   always @(negedge clk) begin
      if (mem_rw) rw_cnt++;
      if (rec && rst_n && (p0_ack | p1_ack)) gq.push_back(p1_ack);
   end

   // issue one access from port p; caller is just after a posedge
   task automatic op(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d, input bit keep,
                     output logic [7:0] rd, output int lat);
      if (p) begin p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d; end
      else begin p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d; end
      lat = -1;
      forever begin
         @(negedge clk);
         lat++;
         if (p ? p1_ack : p0_ack) break;
         if (lat > 40) begin
            total++; bad++;
            $display("FAIL ack_timeout port %0d: got no ack, want ack within 40 cycles", p);
            break;
         end
      end
      rd = p ? p1_rdata : p0_rdata;
      @(posedge clk); #2;
      if (!keep) begin
         if (p) p1_req = 0;
         else p0_req = 0;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1;
   endtask

   logic [7:0] rd0, rd1;
   int l0, l1, diff;
   initial begin
      #1 rst_n = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_rw", 32'(mem_rw), 0);
      end
      diff = 0;
      for (int i = 0; i < 256; i++) if (sram[i] !== 8'(i)) diff++;
      chk("sram_intact", 32'(diff), 0);
      @(posedge clk); #2;
      op(0, 0, 8'h00, 8'h00, 0, rd0, l0); chk("rd_00", 32'(rd0), 32'h00);
      op(0, 0, 8'hFF, 8'h00, 0, rd0, l0); chk("rd_ff", 32'(rd0), 32'hFF);
      // write then read back
      rw_cnt = 0;
      op(0, 1, 8'h3C, 8'hA5, 0, rd0, l0);
      chk("wr_lat", 32'(l0), 2);
      chk("wr_strobe", 32'(rw_cnt), 1);
      op(0, 0, 8'h3C, 8'h00, 0, rd0, l0);
      chk("rd_lat", 32'(l0), 3);
      chk("rd_3c", 32'(rd0), 32'hA5);
      chk("sram_3c", 32'(sram[8'h3C]), 32'hA5);
      // simultaneous writes: port 0 wins first
      gq.delete(); rec = 1;
      fork
         op(0, 1, 8'h10, 8'h11, 0, rd0, l0);
         op(1, 1, 8'h20, 8'h22, 0, rd1, l1);
      join
      rec = 0;
      chk("both_n", 32'(gq.size()), 2);
      if (gq.size() == 2) begin
         chk("both_first", 32'(gq[0]), 0);
         chk("both_second", 32'(gq[1]), 1);
      end
      op(0, 0, 8'h10, 8'h00, 0, rd0, l0); chk("rd_10", 32'(rd0), 32'h11);
      op(1, 0, 8'h20, 8'h00, 0, rd1, l1); chk("rd_20", 32'(rd1), 32'h22);
      chk("p0_rdata_kept", 32'(p0_rdata), 32'h11);
      // continuous contention: grants alternate starting with port 0
      pulse_reset();
      gq.delete(); rec = 1;
      fork
         for (int i = 0; i < 4; i++) op(0, 0, 8'(8'h10 + i), 8'h00, i < 3, rd0, l0);
         for (int j = 0; j < 4; j++) op(1, 0, 8'(8'h20 + j), 8'h00, j < 3, rd1, l1);
      join
      rec = 0;
      chk("alt_n", 32'(gq.size()), 8);
      foreach (gq[k]) chk("alt_order", 32'(gq[k]), 32'(k % 2));
      chk("alt_p0_last", 32'(rd0), 32'h13);
      chk("alt_p1_last", 32'(rd1), 32'h23);
      // reset during a port 1 read, then reissue
      p1_req = 1; p1_we = 0; p1_addr = 8'h20;
      @(posedge clk); #3;
      chk("in_rd_busy", 32'(busy), 1);
      rst_n = 0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ack", 32'(p1_ack), 0);
      chk("arst_rdata", 32'(p1_rdata), 0);
      chk("arst_addr", 32'(mem_addr), 0);
      @(posedge clk); #2 rst_n = 1;
      op(1, 0, 8'h20, 8'h00, 0, rd1, l1);
      chk("reissue_lat", 32'(l1), 3);
      chk("reissue_rd", 32'(rd1), 32'h22);
`ifdef SRAM_ARB_STATS_EN
      pulse_reset();
      for (int i = 0; i < 5; i++) op(0, 1, 8'(8'h80 + i), 8'(i), 0, rd0, l0);
      for (int i = 0; i < 3; i++) op(1, 1, 8'(8'h90 + i), 8'(i), 0, rd1, l1);
      chk("cnt_p0", 32'(p0_grant_cnt), 5);
      chk("cnt_p1", 32'(p1_grant_cnt), 3);
      fork
         op(0, 0, 8'h80, 8'h00, 0, rd0, l0);
         begin
            stats_clr = 1;
            @(posedge clk); #1 stats_clr = 0;
         end
      join
      chk("clr_p0", 32'(p0_grant_cnt), 0);
      chk("clr_p1", 32'(p1_grant_cnt), 0);
`endif
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
